// File: rtl/ysyx_20020207_ifu_if.sv
// Instruction fetch unit signal bundle.
// Groups the PC-register input, the AXI4-Lite read channels and the
// decode handshake. The "master" modport is the IFU's view of the bundle.
// The "slave" modport is the view of the surroundings: PC register, memory and decode.
interface ysyx_20020207_ifu_if #(
  parameter int DATA_WIDTH = 32
);

  // PC register side
  logic [DATA_WIDTH-1:0] pc;
  logic                  pc_ready;

  // AXI4-Lite read address channel
  logic [DATA_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;

  // AXI4-Lite read data channel
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  // Decode side
  logic [DATA_WIDTH-1:0] inst;
  logic [DATA_WIDTH-1:0] inst_pc;
  logic                  inst_valid;
  logic                  inst_ready;
  logic                  inst_fault;

  modport master (
    input  pc, pc_ready,
    output araddr, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready,
    output inst, inst_pc, inst_valid, inst_fault,
    input  inst_ready
  );

  modport slave (
    output pc, pc_ready,
    input  araddr, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready,
    input  inst, inst_pc, inst_valid, inst_fault,
    output inst_ready
  );

endinterface

// File: rtl/ysyx_20020207_ifu.sv
// Instruction fetch unit.
// Each pc_ready pulse seen in IDLE triggers exactly one AXI4-Lite read.
// The returned word is held on inst/inst_pc until decode accepts it.
// The optional fault reporting is enabled by defining YSYX_20020207_IFU_FAULT_EN.
// It covers misaligned PCs and non-OKAY read responses.
// Without the macro, inst_fault is tied low and rresp is ignored.
module ysyx_20020207_ifu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  ysyx_20020207_ifu_if.master       bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [DATA_WIDTH-1:0] araddr_q;
  logic [DATA_WIDTH-1:0] inst_q;
  logic [DATA_WIDTH-1:0] inst_pc_q;

  logic arvalid_d;
  logic rready_d;
  logic inst_valid_d;

  logic misaligned;

`ifdef YSYX_20020207_IFU_FAULT_EN
  logic fault_q;

  // A PC that is not word aligned cannot be fetched; it is reported as a fault
  assign misaligned = (bus.pc[1:0] != 2'b00);
`else
  logic unused_rresp;

  assign misaligned   = 1'b0;
  assign unused_rresp = ^bus.rresp;
`endif

  // State register: reset always forces IDLE, even in the middle of a transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: each state looks only at its own handshake, so simultaneous events resolve by state order
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.pc_ready) begin
          state_next = misaligned ? HOLD : ADDR;
        end
      end
      ADDR: begin
        if (bus.arready) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (bus.rvalid) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (bus.inst_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode: handshake strobes come straight from the registered state, so they are glitch-free
  always_comb begin
    arvalid_d    = 1'b0;
    rready_d     = 1'b0;
    inst_valid_d = 1'b0;
    case (state)
      ADDR:    arvalid_d    = 1'b1;
      DATA:    rready_d     = 1'b1;
      HOLD:    inst_valid_d = 1'b1;
      default: begin
        arvalid_d    = 1'b0;
        rready_d     = 1'b0;
        inst_valid_d = 1'b0;
      end
    endcase
  end

  // Address/PC capture: latched once in IDLE, then held stable until the next fetch starts
  always_ff @(posedge clk) begin
    if (rst) begin
      araddr_q  <= '0;
      inst_pc_q <= '0;
    end else if (state == IDLE && bus.pc_ready) begin
      araddr_q  <= bus.pc;
      inst_pc_q <= bus.pc;
    end
  end

  // Instruction capture: the read data is taken only in DATA; a misaligned PC yields a zero word
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q <= '0;
    end else if (state == IDLE && bus.pc_ready && misaligned) begin
      inst_q <= '0;
    end else if (state == DATA && bus.rvalid) begin
      inst_q <= bus.rdata;
    end
  end

`ifdef YSYX_20020207_IFU_FAULT_EN
  // Fault flag: set by a misaligned PC or a non-OKAY response, and refreshed by every completed fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (state == IDLE && bus.pc_ready && misaligned) begin
      fault_q <= 1'b1;
    end else if (state == DATA && bus.rvalid) begin
      fault_q <= (bus.rresp != 2'b00);
    end
  end

  assign bus.inst_fault = fault_q;
`else
  assign bus.inst_fault = 1'b0;
`endif

  assign bus.araddr     = araddr_q;
  assign bus.arvalid    = arvalid_d;
  assign bus.rready     = rready_d;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_valid = inst_valid_d;

endmodule

// File: tb/tb_ysyx_20020207_ifu.sv
// Directed testbench for ysyx_20020207_ifu.
// Inputs change on the falling edge, and outputs are sampled on the falling edge before new inputs are applied.
// The expected fault behaviour follows YSYX_20020207_IFU_FAULT_EN.
module tb_ysyx_20020207_ifu;

  logic clk;
  logic rst;

  int checks   = 0;
  int failures = 0;
  int ar_count = 0;
  int ar_base  = 0;

`ifdef YSYX_20020207_IFU_FAULT_EN
  localparam logic FAULT_EXP = 1'b1;
`else
  localparam logic FAULT_EXP = 1'b0;
`endif

  ysyx_20020207_ifu_if #(.DATA_WIDTH(32)) bus ();

  ysyx_20020207_ifu #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count accepted read-address handshakes
  always @(posedge clk) begin
    if (bus.arvalid === 1'b1 && bus.arready === 1'b1) begin
      ar_count <= ar_count + 1;
    end
  end

  // Drive every DUT input for the current cycle
  task automatic applyStimulus(input logic r, input logic [31:0] p, input logic pr,
                               input logic ar, input logic rv, input logic [31:0] rd,
                               input logic [1:0] rs, input logic ir);
    rst            = r;
    bus.pc         = p;
    bus.pc_ready   = pr;
    bus.arready    = ar;
    bus.rvalid     = rv;
    bus.rdata      = rd;
    bus.rresp      = rs;
    bus.inst_ready = ir;
  endtask

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Directed test sequence
  initial begin
    applyStimulus(1'b1, 32'h3000_0000, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst_arvalid",    {31'b0, bus.arvalid},    32'h0);
    checkOutput("rst_rready",     {31'b0, bus.rready},     32'h0);
    checkOutput("rst_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
    checkOutput("rst_inst_fault", {31'b0, bus.inst_fault}, 32'h0);
    checkOutput("rst_araddr",     bus.araddr,              32'h0);
    checkOutput("rst_inst",       bus.inst,                32'h0);
    checkOutput("rst_inst_pc",    bus.inst_pc,             32'h0);

    $display("[TB] first fetch after reset, zero wait states");
    applyStimulus(1'b0, 32'h3000_0000, 1'b1, 1'b1, 1'b1, 32'h0000_0413, 2'd0, 1'b0);
    @(negedge clk);
    checkOutput("t1_c1_arvalid",    {31'b0, bus.arvalid},    32'h1);
    checkOutput("t1_c1_araddr",     bus.araddr,              32'h3000_0000);
    checkOutput("t1_c1_rready",     {31'b0, bus.rready},     32'h0);
    checkOutput("t1_c1_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
    applyStimulus(1'b0, 32'h3000_0000, 1'b0, 1'b1, 1'b1, 32'h0000_0413, 2'd0, 1'b0);
    @(negedge clk);
    checkOutput("t1_c2_arvalid",    {31'b0, bus.arvalid},    32'h0);
    checkOutput("t1_c2_rready",     {31'b0, bus.rready},     32'h1);
    checkOutput("t1_c2_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
    @(negedge clk);
    checkOutput("t1_c3_inst_valid", {31'b0, bus.inst_valid}, 32'h1);
    checkOutput("t1_c3_inst",       bus.inst,                32'h0000_0413);
    checkOutput("t1_c3_inst_pc",    bus.inst_pc,             32'h3000_0000);
    checkOutput("t1_c3_inst_fault", {31'b0, bus.inst_fault}, 32'h0);
    checkOutput("t1_c3_rready",     {31'b0, bus.rready},     32'h0);

    $display("[TB] decode stall with stray pc_ready");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, (i == 2) ? 32'h3000_0004 : 32'h3000_0000, (i == 2),
                    1'b1, 1'b1, 32'hCAFE_F00D, 2'd0, 1'b0);
      @(negedge clk);
      checkOutput("t3_hold_inst_valid", {31'b0, bus.inst_valid}, 32'h1);
      checkOutput("t3_hold_inst",       bus.inst,                32'h0000_0413);
      checkOutput("t3_hold_inst_pc",    bus.inst_pc,             32'h3000_0000);
      checkOutput("t3_hold_arvalid",    {31'b0, bus.arvalid},    32'h0);
    end
    applyStimulus(1'b0, 32'h3000_0004, 1'b1, 1'b1, 1'b1, 32'hCAFE_F00D, 2'd0, 1'b1);
    @(negedge clk);
    checkOutput("t3_release_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
    checkOutput("t3_release_arvalid",    {31'b0, bus.arvalid},    32'h0);
    applyStimulus(1'b0, 32'h3000_0004, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
    @(negedge clk);
    checkOutput("t3_idle_arvalid",    {31'b0, bus.arvalid},    32'h0);
    checkOutput("t3_idle_inst_valid", {31'b0, bus.inst_valid}, 32'h0);

    $display("[TB] fetch with bus wait states");
    ar_base = ar_count;
    applyStimulus(1'b0, 32'h3000_0004, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      checkOutput("t2_latency_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
      if (c <= 5) begin
        checkOutput("t2_addr_arvalid", {31'b0, bus.arvalid}, 32'h1);
        checkOutput("t2_addr_araddr",  bus.araddr,           32'h3000_0004);
      end else begin
        checkOutput("t2_data_rready",  {31'b0, bus.rready},  32'h1);
        checkOutput("t2_data_arvalid", {31'b0, bus.arvalid}, 32'h0);
      end
      applyStimulus(1'b0, 32'hDEAD_0000, 1'b0, (c == 5), (c == 9),
                    32'h0010_0093, 2'd0, 1'b0);
    end
    @(negedge clk);
    checkOutput("t2_c10_inst_valid", {31'b0, bus.inst_valid}, 32'h1);
    checkOutput("t2_c10_inst",       bus.inst,                32'h0010_0093);
    checkOutput("t2_c10_inst_pc",    bus.inst_pc,             32'h3000_0004);
    checkOutput("t2_ar_handshakes",  ar_count - ar_base,      32'd1);
    applyStimulus(1'b0, 32'h3000_0004, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1);
    @(negedge clk);
    checkOutput("t2_done_inst_valid", {31'b0, bus.inst_valid}, 32'h0);

    $display("[TB] reset during DATA");
    applyStimulus(1'b0, 32'h3000_0008, 1'b1, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0);
    @(negedge clk);
    checkOutput("t4_c1_arvalid", {31'b0, bus.arvalid}, 32'h1);
    applyStimulus(1'b0, 32'h3000_0008, 1'b0, 1'b1, 1'b0, 32'h0, 2'd0, 1'b0);
    @(negedge clk);
    checkOutput("t4_c2_rready", {31'b0, bus.rready}, 32'h1);
    applyStimulus(1'b1, 32'h3000_0008, 1'b0, 1'b1, 1'b1, 32'h0BAD_0BAD, 2'd0, 1'b0);
    @(negedge clk);
    checkOutput("t4_rst_arvalid",    {31'b0, bus.arvalid},    32'h0);
    checkOutput("t4_rst_rready",     {31'b0, bus.rready},     32'h0);
    checkOutput("t4_rst_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
    checkOutput("t4_rst_inst_fault", {31'b0, bus.inst_fault}, 32'h0);
    checkOutput("t4_rst_araddr",     bus.araddr,              32'h0);
    checkOutput("t4_rst_inst",       bus.inst,                32'h0);
    checkOutput("t4_rst_inst_pc",    bus.inst_pc,             32'h0);
    applyStimulus(1'b0, 32'h3000_0008, 1'b0, 1'b1, 1'b1, 32'h0BAD_0BAD, 2'd2, 1'b0);
    @(negedge clk);
    checkOutput("t4_late_rready",     {31'b0, bus.rready},     32'h0);
    checkOutput("t4_late_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
    checkOutput("t4_late_arvalid",    {31'b0, bus.arvalid},    32'h0);
    applyStimulus(1'b0, 32'h3000_000C, 1'b1, 1'b1, 1'b1, 32'h0000_0013, 2'd0, 1'b0);
    @(negedge clk);
    checkOutput("t4_clean_arvalid", {31'b0, bus.arvalid}, 32'h1);
    checkOutput("t4_clean_araddr",  bus.araddr,           32'h3000_000C);
    applyStimulus(1'b0, 32'h3000_000C, 1'b0, 1'b1, 1'b1, 32'h0000_0013, 2'd0, 1'b0);
    @(negedge clk);
    checkOutput("t4_clean_rready", {31'b0, bus.rready}, 32'h1);
    @(negedge clk);
    checkOutput("t4_clean_inst_valid", {31'b0, bus.inst_valid}, 32'h1);
    checkOutput("t4_clean_inst",       bus.inst,                32'h0000_0013);
    checkOutput("t4_clean_inst_pc",    bus.inst_pc,             32'h3000_000C);
    checkOutput("t4_clean_inst_fault", {31'b0, bus.inst_fault}, 32'h0);
    applyStimulus(1'b0, 32'h3000_000C, 1'b0, 1'b1, 1'b1, 32'h0000_0013, 2'd0, 1'b1);
    @(negedge clk);
    checkOutput("t4_done_inst_valid", {31'b0, bus.inst_valid}, 32'h0);

    $display("[TB] bus error response");
    applyStimulus(1'b0, 32'h3000_0010, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 2'd2, 1'b0);
    @(negedge clk);
    checkOutput("t5_err_arvalid", {31'b0, bus.arvalid}, 32'h1);
    applyStimulus(1'b0, 32'h3000_0010, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 2'd2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t5_err_inst_valid", {31'b0, bus.inst_valid}, 32'h1);
    checkOutput("t5_err_inst",       bus.inst,                32'hFFFF_FFFF);
    checkOutput("t5_err_inst_fault", {31'b0, bus.inst_fault}, {31'b0, FAULT_EXP});
    applyStimulus(1'b0, 32'h3000_0010, 1'b0, 1'b1, 1'b1, 32'h0, 2'd0, 1'b1);
    @(negedge clk);
    checkOutput("t5_err_done_inst_valid", {31'b0, bus.inst_valid}, 32'h0);

    $display("[TB] misaligned pc");
    applyStimulus(1'b0, 32'h3000_0002, 1'b1, 1'b1, 1'b1, 32'h0000_0022, 2'd0, 1'b0);
    @(negedge clk);
`ifdef YSYX_20020207_IFU_FAULT_EN
    checkOutput("t5_mis_arvalid",    {31'b0, bus.arvalid},    32'h0);
    checkOutput("t5_mis_inst_valid", {31'b0, bus.inst_valid}, 32'h1);
    checkOutput("t5_mis_inst",       bus.inst,                32'h0);
    checkOutput("t5_mis_inst_pc",    bus.inst_pc,             32'h3000_0002);
    checkOutput("t5_mis_inst_fault", {31'b0, bus.inst_fault}, 32'h1);
    applyStimulus(1'b0, 32'h3000_0002, 1'b0, 1'b1, 1'b1, 32'h0, 2'd0, 1'b1);
    @(negedge clk);
    checkOutput("t5_mis_done_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
`else
    checkOutput("t5_mis_arvalid", {31'b0, bus.arvalid}, 32'h1);
    checkOutput("t5_mis_araddr",  bus.araddr,           32'h3000_0002);
    applyStimulus(1'b0, 32'h3000_0002, 1'b0, 1'b1, 1'b1, 32'h0000_0022, 2'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t5_mis_inst_valid", {31'b0, bus.inst_valid}, 32'h1);
    checkOutput("t5_mis_inst",       bus.inst,                32'h0000_0022);
    checkOutput("t5_mis_inst_fault", {31'b0, bus.inst_fault}, 32'h0);
    applyStimulus(1'b0, 32'h3000_0002, 1'b0, 1'b1, 1'b1, 32'h0, 2'd0, 1'b1);
    @(negedge clk);
    checkOutput("t5_mis_done_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
